// File: rtl/fft_frame_controller_pkg.sv
// Shared types and constants for the 32-point FFT frame controller.
package fft_ctrl_pkg;

  localparam int FFT_N      = 32;
  localparam int FFT_ADDR_W = 5;
  localparam int FFT_LEVELS = 5;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_KICK,
    ST_WAIT_LOW,
    ST_WAIT_DONE,
    ST_UNLOAD
  } fft_state_e;

  function automatic logic [FFT_ADDR_W-1:0] bitrev5(input logic [FFT_ADDR_W-1:0] a);
    logic [FFT_ADDR_W-1:0] r;
    for (int i = 0; i < FFT_LEVELS; i++) r[i] = a[FFT_LEVELS-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_controller_if.sv
// Sample streams, working-memory port and FFT core handshake of the frame controller.
interface fft_frame_controller_if #(parameter int DATA_W = 32);
  import fft_ctrl_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  mem_sel;
  logic                  mem_wr_en;
  logic [FFT_ADDR_W-1:0] mem_wr_address;
  logic [DATA_W-1:0]     mem_wr_data;
  logic                  mem_rd_en;
  logic [FFT_ADDR_W-1:0] mem_rd_address;
  logic [DATA_W-1:0]     mem_rd_data;
  logic                  start_fft;
  logic                  fft_done;

  modport master (
    input  in_valid, in_data, out_ready, mem_rd_data, fft_done,
    output in_ready, out_valid, out_data, mem_sel, mem_wr_en, mem_wr_address,
           mem_wr_data, mem_rd_en, mem_rd_address, start_fft
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rd_data, fft_done,
    input  in_ready, out_valid, out_data, mem_sel, mem_wr_en, mem_wr_address,
           mem_wr_data, mem_rd_en, mem_rd_address, start_fft
  );

endinterface

// File: rtl/fft_frame_controller_out_skid.sv
// Two-entry output buffer; occupancy feeds the read-issue throttle in the controller.
module fft_out_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] entry [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              pop;

  assign valid = (count != 2'd0);
  assign pop   = valid && ready;
  assign data  = entry[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/fft_frame_controller.sv
// Frame sequencer: load 32 samples, run the FFT core, unload 32 results with backpressure.
// Build option FFT_BITREV_UNLOAD_EN: unload reads use bit-reversed addresses.
//
// state        | meaning
// ST_LOAD      | accepting input samples into working memory
// ST_KICK      | one-cycle start pulse, memory handed to the datapath
// ST_WAIT_LOW  | waiting for fft_done to drop; watchdog running
// ST_WAIT_DONE | transform running, waiting for fft_done to rise
// ST_UNLOAD    | reading results out through the output buffer
module fft_frame_controller
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_frame_controller_if.master  bus,
  output logic [7:0]              frame_count,
  output logic                    timeout_err
);

  localparam int WD_W = $clog2(DONE_TIMEOUT) + 1;

  fft_state_e            state, state_nxt;
  logic [FFT_ADDR_W-1:0] cnt;
  logic [FFT_ADDR_W-1:0] out_cnt;
  logic                  issue_done;
  logic                  rd_inflight;
  logic [WD_W-1:0]       wd_cnt;
  logic [1:0]            skid_count;
  logic [2:0]            occ_eff;
  logic                  accept, issue, out_fire, last_out, wd_expired;
  logic [FFT_ADDR_W-1:0] rd_addr;

  assign accept     = (state == ST_LOAD) && bus.in_valid;
  assign out_fire   = bus.out_valid && bus.out_ready;
  assign last_out   = out_fire && (out_cnt == FFT_ADDR_W'(FFT_N - 1));
  assign wd_expired = (wd_cnt == '0);
  // a pop in this cycle frees its slot, so issue and pop overlap for full throughput
  assign occ_eff    = {1'b0, skid_count} + {2'b00, rd_inflight} - {2'b00, out_fire};
  assign issue      = (state == ST_UNLOAD) && !issue_done && (occ_eff < 3'd2);

`ifdef FFT_BITREV_UNLOAD_EN
  assign rd_addr = bitrev5(cnt);
`else
  assign rd_addr = cnt;
`endif

  always_comb begin
    state_nxt          = state;
    bus.in_ready       = 1'b0;
    bus.start_fft      = 1'b0;
    bus.mem_sel        = 1'b0;
    bus.mem_rd_en      = issue;
    bus.mem_rd_address = rd_addr;
    unique case (state)
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        if (accept && cnt == FFT_ADDR_W'(FFT_N - 1)) state_nxt = ST_KICK;
      end
      ST_KICK: begin
        bus.start_fft = 1'b1;
        bus.mem_sel   = 1'b1;
        state_nxt     = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        bus.mem_sel = 1'b1;
        if (!bus.fft_done)     state_nxt = ST_WAIT_DONE;
        else if (wd_expired)   state_nxt = ST_LOAD;
      end
      ST_WAIT_DONE: begin
        bus.mem_sel = 1'b1;
        if (bus.fft_done) state_nxt = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (last_out) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_LOAD;
      cnt                <= '0;
      out_cnt            <= '0;
      issue_done         <= 1'b0;
      rd_inflight        <= 1'b0;
      wd_cnt             <= '0;
      frame_count        <= 8'd0;
      timeout_err        <= 1'b0;
      bus.mem_wr_en      <= 1'b0;
      bus.mem_wr_address <= '0;
      bus.mem_wr_data    <= '0;
    end else begin
      state         <= state_nxt;
      rd_inflight   <= issue;
      bus.mem_wr_en <= accept;
      if (accept) begin
        bus.mem_wr_address <= cnt;
        bus.mem_wr_data    <= bus.in_data;
      end
      unique case (state)
        ST_LOAD: if (accept) cnt <= cnt + 1'b1;
        // terminal count lands on the cycle that is DONE_TIMEOUT after the kick
        ST_KICK: wd_cnt <= WD_W'(DONE_TIMEOUT - 2);
        ST_WAIT_LOW: begin
          if (bus.fft_done) begin
            if (wd_expired) begin
              timeout_err <= 1'b1;
              cnt         <= '0;
            end else begin
              wd_cnt <= wd_cnt - 1'b1;
            end
          end
        end
        ST_UNLOAD: begin
          if (issue) begin
            cnt <= cnt + 1'b1;
            if (cnt == FFT_ADDR_W'(FFT_N - 1)) issue_done <= 1'b1;
          end
          if (out_fire) out_cnt <= out_cnt + 1'b1;
          if (last_out) begin
            frame_count <= frame_count + 8'd1;
            cnt         <= '0;
            out_cnt     <= '0;
            issue_done  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  fft_out_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data (bus.mem_rd_data),
    .ready     (bus.out_ready),
    .valid     (bus.out_valid),
    .data      (bus.out_data),
    .count     (skid_count)
  );

endmodule

// File: tb/tb_fft_frame_controller.sv
// Directed bench for fft_frame_controller: table of frame scenarios plus reset-abort sequence.
module tb_fft_frame_controller;

  logic clk;
  logic rst;
  logic [7:0] frame_count;
  logic timeout_err;
  int checks = 0;
  int failures = 0;

  fft_frame_controller_if #(.DATA_W(32)) ifc ();

  fft_frame_controller #(.DATA_W(32), .DONE_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc.master),
    .frame_count (frame_count),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // working-memory model: write strobe, read data one cycle after the read strobe
  logic [31:0] mem_m [32];
  always @(posedge clk) begin
    if (ifc.mem_wr_en) mem_m[ifc.mem_wr_address] <= ifc.mem_wr_data;
    if (ifc.mem_rd_en) ifc.mem_rd_data <= mem_m[ifc.mem_rd_address];
  end

  typedef struct {
    logic [31:0] base;
    bit          rand_ready;
    int          drop;
    int          busy;
    bit          hang;
    int          exp_fc;
    bit          exp_to;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int rd_index(input int k);
`ifdef FFT_BITREV_UNLOAD_EN
    logic [4:0] a, r;
    a = k[4:0];
    for (int i = 0; i < 5; i++) r[i] = a[4-i];
    return int'(r);
`else
    return k;
`endif
  endfunction

  task automatic check_reset_values();
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_data", ifc.out_data, 0);
    check("rst_mem_sel", ifc.mem_sel, 0);
    check("rst_start_fft", ifc.start_fft, 0);
    check("rst_wr_en", ifc.mem_wr_en, 0);
    check("rst_rd_en", ifc.mem_rd_en, 0);
    check("rst_wr_addr", ifc.mem_wr_address, 0);
    check("rst_rd_addr", ifc.mem_rd_address, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_timeout_err", timeout_err, 0);
  endtask

  // Runs one frame starting #1 after an edge in LOAD. abort_at >= 0 applies reset
  // once that many outputs have been taken.
  task automatic run_frame(input vec_t v, input int abort_at);
    logic [31:0] samp [32];
    logic [31:0] exp_q [32];
    int cyc, got, issued, first_v, last_hs;
    bit r, stalled;
    logic [31:0] prev;
    for (int k = 0; k < 32; k++) samp[k] = v.base + 32'(k);
    for (int k = 0; k < 32; k++) exp_q[k] = samp[rd_index(k)];
    ifc.fft_done = 1'b1;
    ifc.out_ready = 1'b0;

    for (int k = 0; k < 32; k++) begin
      check("load_ready", ifc.in_ready, 1);
      ifc.in_valid = 1'b1;
      ifc.in_data = samp[k];
      @(posedge clk); #1;
      check("wr_en", ifc.mem_wr_en, 1);
      check("wr_addr", ifc.mem_wr_address, 64'(k));
      check("wr_data", ifc.mem_wr_data, samp[k]);
    end
    ifc.in_valid = 1'b0;
    check("kick_start", ifc.start_fft, 1);
    check("kick_sel", ifc.mem_sel, 1);
    check("kick_ready", ifc.in_ready, 0);
    @(posedge clk); #1;
    check("start_once", ifc.start_fft, 0);
    check("wr_en_after_load", ifc.mem_wr_en, 0);

    if (v.hang) begin
      repeat (14) begin @(posedge clk); #1; end
      check("wd_still_waiting", ifc.mem_sel, 1);
      @(posedge clk); #1;
      check("timeout_set", timeout_err, 1);
      check("timeout_to_load", ifc.in_ready, 1);
      check("timeout_sel", ifc.mem_sel, 0);
      check("timeout_frame_count", frame_count, 64'(v.exp_fc));
      return;
    end

    repeat (v.drop - 1) begin @(posedge clk); #1; end
    ifc.fft_done = 1'b0;
    repeat (v.busy) begin @(posedge clk); #1; end
    check("busy_sel", ifc.mem_sel, 1);
    check("busy_no_out", ifc.out_valid, 0);
    ifc.fft_done = 1'b1;
    @(posedge clk); #1;
    check("unload_sel", ifc.mem_sel, 0);
    check("unload_ready", ifc.in_ready, 0);

    cyc = 0; got = 0; issued = 0; first_v = -1; last_hs = -1; stalled = 0; prev = '0;
    while (got < 32 && cyc < 400) begin
      if (got == abort_at) begin
        rst = 1'b1;
        ifc.out_ready = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_abort_ready", ifc.in_ready, 1);
        return;
      end
      r = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.out_ready = r;
      #1;
      if (ifc.mem_rd_en) begin
        check("rd_addr_seq", ifc.mem_rd_address, 64'(rd_index(issued)));
        issued++;
      end
      if (stalled) begin
        check("stall_valid", ifc.out_valid, 1);
        check("stall_data", ifc.out_data, prev);
      end
      if (ifc.out_valid && first_v < 0) first_v = cyc;
      if (ifc.out_valid && r) begin
        check("out_data", ifc.out_data, exp_q[got]);
        got++;
        last_hs = cyc;
      end
      stalled = ifc.out_valid && !r;
      prev = ifc.out_data;
      @(posedge clk); #1;
      cyc++;
    end
    ifc.out_ready = 1'b0;
    check("unload_outputs", 64'(got), 32);
    check("unload_reads", 64'(issued), 32);
    if (!v.rand_ready) begin
      check("first_valid_lat", 64'(first_v), 2);
      check("last_hs_cycle", 64'(last_hs), 33);
    end
    check("frame_count", frame_count, 64'(v.exp_fc));
    check("timeout_sticky", timeout_err, 64'(v.exp_to));
    check("back_to_load", ifc.in_ready, 1);
  endtask

  vec_t tbl [5];
  vec_t rv;

  initial begin
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    ifc.out_ready = 1'b0;
    ifc.fft_done = 1'b1;

    tbl[0] = '{base: 32'h0000_0000, rand_ready: 0, drop: 3, busy: 40, hang: 0, exp_fc: 1, exp_to: 0};
    tbl[1] = '{base: 32'h0000_0100, rand_ready: 1, drop: 3, busy: 10, hang: 0, exp_fc: 2, exp_to: 0};
    tbl[2] = '{base: 32'hA5A5_0000, rand_ready: 0, drop: 1, busy: 1,  hang: 0, exp_fc: 3, exp_to: 0};
    tbl[3] = '{base: 32'h0000_0077, rand_ready: 0, drop: 0, busy: 0,  hang: 1, exp_fc: 3, exp_to: 1};
    tbl[4] = '{base: 32'h0000_5000, rand_ready: 1, drop: 2, busy: 6,  hang: 0, exp_fc: 4, exp_to: 1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", ifc.in_ready, 1);

    for (int i = 0; i < 5; i++) run_frame(tbl[i], -1);

    // reset in the middle of unload, then a clean frame from scratch
    rv = '{base: 32'h0000_0900, rand_ready: 0, drop: 3, busy: 8, hang: 0, exp_fc: 0, exp_to: 0};
    run_frame(rv, 20);
    rv = '{base: 32'h0000_0C00, rand_ready: 0, drop: 3, busy: 12, hang: 0, exp_fc: 1, exp_to: 0};
    run_frame(rv, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/fft_frame_controller.md
# fft_frame_controller

Frame-level sequencer for the 32-point radix-2 FFT core. Streams 32 input samples into the working memory, triggers the address generation unit, waits for transform completion, then streams the 32 results out with backpressure. Owns the memory-port mux between itself (load/unload) and the FFT datapath (butterfly passes).

## Interface

Parameters:
- `DATA_W`, 32: sample width (packed complex).
- `DONE_TIMEOUT`, 16: max cycles from `start_fft` until `fft_done` must read low.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset; asynchronous, active-high.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: controller accepts a sample.
- `in_data` in DATA_W: input sample.
- `mem_sel` out 1: memory-port owner; 0 = controller, 1 = FFT datapath.
- `mem_wr_en` out 1: controller write strobe.
- `mem_wr_address` out 5: controller write address.
- `mem_wr_data` out DATA_W: controller write data, equal to `in_data` registered.
- `mem_rd_en` out 1: controller read strobe.
- `mem_rd_address` out 5: controller read address.
- `mem_rd_data` in DATA_W: read data, valid exactly 1 cycle after `mem_rd_en`.
- `start_fft` out 1: one-cycle start pulse to the address generation unit.
- `fft_done` in 1: level signal from the address generation unit. It is high while the unit is idle.
- `out_valid` out 1: output sample valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out DATA_W: output sample.
- `frame_count` out 8: completed frames, wraps 255→0.
- `timeout_err` out 1: sticky watchdog flag.

## Operation

- States: `LOAD`, `KICK`, `WAIT_LOW`, `WAIT_DONE`, `UNLOAD`.
- `LOAD`:
  - `in_ready`=1 and `mem_sel`=0.
  - When `in_valid&in_ready`: write `in_data` to address `cnt`, then `cnt++`.
  - After the 32nd accept (`cnt`=31), go to `KICK`. `cnt` wraps to 0.
- `KICK`: `start_fft`=1 for exactly one cycle, `mem_sel`=1, `in_ready`=0. Next state is `WAIT_LOW`.
- `WAIT_LOW`:
  - `fft_done` is high before the core starts, so it is ignored here until it reads 0. Then go to `WAIT_DONE`.
  - Watchdog counts cycles from `KICK`. If it reaches `DONE_TIMEOUT` with `fft_done` still high: set `timeout_err`, clear `cnt`, go to `LOAD`. The frame is discarded and `frame_count` does not increment.
- `WAIT_DONE`: on `fft_done`=1, go to `UNLOAD` and set `mem_sel`=0 in the same transition.
- `UNLOAD`:
  - Read addresses are issued for `cnt`=0..31. The address is `cnt` directly or bit-reversed (see Configuration).
  - A 2-entry output buffer holds returned data. A read is issued only when (buffer occupancy + reads in flight) < 2. This gives full throughput while `out_ready`=1.
  - After the 32nd output handshake: `frame_count++`, `cnt`=0, go to `LOAD`.
- `timeout_err` clears only on `rst`.
- Simultaneous events:
  - In `LOAD`, `in_valid` together with the transition to `KICK` cannot occur; `in_ready` is already 0 in `KICK`.
  - In the last `UNLOAD` cycle, `in_ready` stays 0; the next frame load starts the following cycle.

## Timing

- Reset values:
  - State `LOAD`, `cnt`=0, `frame_count`=0, `timeout_err`=0.
  - `mem_sel`=0.
  - `start_fft`, `mem_wr_en`, `mem_rd_en`, `out_valid`=0.
  - `in_ready`=1 from the first cycle after `rst` deasserts.
  - `out_data`=0, `mem_wr_address`/`mem_rd_address`=0.
- Load path: `mem_wr_en`/`mem_wr_address`/`mem_wr_data` are registered and appear 1 cycle after the accept handshake.
- Unload path: `out_valid` rises 2 cycles after entering `UNLOAD` (read issue, then data capture). Minimum unload time is 33 cycles with `out_ready` held at 1.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `mem_sel` switches to 1 in the `KICK` cycle and stays 1 until `WAIT_DONE` exits.
- `rst` asserted mid-frame aborts immediately to reset values. Buffered data is dropped.

## Configuration

- `FFT_BITREV_UNLOAD_EN`:
  - Defined: `mem_rd_address` = bit-reverse(`cnt`), i.e. {cnt[0],cnt[1],cnt[2],cnt[3],cnt[4]}. Results leave in natural frequency order.
  - Undefined: `mem_rd_address` = `cnt`.
- Load addressing is unaffected by the macro.

## Structure

- Package `fft_ctrl_pkg`:
  - State enum.
  - `FFT_N`=32, `FFT_ADDR_W`=5, `FFT_LEVELS`=5.
  - `bitrev5` function.
- Sub-module `fft_out_skid`: 2-entry buffer with valid/ready out. It reports occupancy to the read-issue logic.

## Test plan

- Reset, then feed 32 samples 0..31 with `in_valid` held high → `mem_wr_address` 0..31 on consecutive cycles; one `start_fft` pulse; `mem_sel`=1.
- Model `fft_done`: high, drops 3 cycles after the pulse, rises 40 cycles later → `UNLOAD` entered. With `out_ready`=1, 32 outputs in 33 cycles; `frame_count`=1.
- With `FFT_BITREV_UNLOAD_EN` defined → read address sequence 0,16,8,24,4,… and `out_data` order matches.
- `out_ready` toggled randomly (≈50%) → no lost or duplicated samples; `out_data` held stable during stalls.
- Hold `fft_done`=1 after `KICK` → `timeout_err`=1 at cycle 16; state returns to `LOAD`; `frame_count` unchanged.
- Assert `rst` at sample 20 of `UNLOAD` → all outputs return to reset values; the next full frame completes normally.
